// File: rtl/ads_adc_pkg.sv
// Shared types and constants for the multi-channel TDM ADC device model.
package ads_adc_pkg;

   localparam int unsigned FRAME_CNT_W = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONVERT = 2'd1,
      SHIFT   = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      PAT_FIXED  = 2'd0,
      PAT_CH_TAG = 2'd1,
      PAT_RAMP   = 2'd2,
      PAT_ALT    = 2'd3
   } pattern_t;

endpackage

// File: rtl/ads_pattern_gen.sv
// Builds the per-channel sample words for one frame; ch0 occupies the most significant slot.
module ads_pattern_gen
   import ads_adc_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 24,
   parameter int unsigned NUM_CH     = 4
) (
   input  logic [1:0]                   pattern_sel,
   input  logic [DATA_WIDTH-1:0]        fixed_word,
   input  logic [DATA_WIDTH-1:0]        ramp_cnt,
   input  logic                         alt_phase,
   output logic [NUM_CH*DATA_WIDTH-1:0] words
);

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      localparam logic [DATA_WIDTH-1:0] ChIdx = DATA_WIDTH'(g);
      localparam logic [3:0]            ChTag = 4'(g);
      logic [DATA_WIDTH-1:0] word;

      always_comb begin
         word = fixed_word;
         case (pattern_t'(pattern_sel))
            PAT_FIXED:  word = fixed_word;
            PAT_CH_TAG: word = {fixed_word[DATA_WIDTH-1:4], ChTag};
            PAT_RAMP:   word = ramp_cnt + ChIdx;
            PAT_ALT:    word = alt_phase ? ~fixed_word : fixed_word;
            default:    word = fixed_word;
         endcase
      end

      assign words[(NUM_CH-1-g)*DATA_WIDTH +: DATA_WIDTH] = word;
   end

endmodule

// File: rtl/ads_tdm_adc_model.sv
// Multi-channel serial ADC model: convert interval, then a TDM frame of NUM_CH words, MSB first.
module ads_tdm_adc_model
   import ads_adc_pkg::*;
#(
   parameter int unsigned DATA_WIDTH    = 24,
   parameter int unsigned NUM_CH        = 4,
   parameter int unsigned CONV_CYCLES   = 16,
   parameter bit          FS_ACTIVE_LOW = 1'b1
) (
   input  logic                   clkx,
   input  logic                   rst,
   output logic                   clkr,
   input  logic                   fsx,
   input  logic                   start,
   input  logic                   continuous,
   input  logic [1:0]             pattern_sel,
   input  logic [DATA_WIDTH-1:0]  fixed_word,
   output logic                   drdy_n,
   output logic                   fsr,
   output logic                   drr,
   output logic                   busy,
   output logic [FRAME_CNT_W-1:0] frame_cnt
);

   localparam int unsigned FrameBits = NUM_CH * DATA_WIDTH;
   localparam int unsigned IdxW      = $clog2(FrameBits);
   localparam int unsigned ConvW     = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
   localparam logic [IdxW-1:0]  LastBit  = IdxW'(FrameBits - 1);
   localparam logic [ConvW-1:0] LastConv = ConvW'(CONV_CYCLES - 1);

   state_t                   state_q, state_d;
   logic [ConvW-1:0]         conv_cnt_q, conv_cnt_d;
   logic [IdxW-1:0]          bit_idx_q, bit_idx_d;
   logic [FrameBits-1:0]     shreg_q, shreg_d;
   logic                     drr_q, drr_d;
   logic                     drdy_n_q, drdy_n_d;
   logic [FRAME_CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
   logic [DATA_WIDTH-1:0]    ramp_q, ramp_d;
   logic                     alt_q, alt_d;
   logic [FrameBits-1:0]     words;
   logic                     unused_fsx;

   assign unused_fsx = fsx;

   ads_pattern_gen #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_CH     (NUM_CH)
   ) u_pattern_gen (
      .pattern_sel (pattern_sel),
      .fixed_word  (fixed_word),
      .ramp_cnt    (ramp_q),
      .alt_phase   (alt_q),
      .words       (words)
   );

   always_comb begin
      state_d     = state_q;
      conv_cnt_d  = conv_cnt_q;
      bit_idx_d   = bit_idx_q;
      shreg_d     = shreg_q;
      drr_d       = 1'b0;
      drdy_n_d    = 1'b1;
      frame_cnt_d = frame_cnt_q;
      ramp_d      = ramp_q;
      alt_d       = alt_q;
      // A start pulse always (re)starts the interval, discarding any frame in flight.
      if (start) begin
         state_d    = CONVERT;
         conv_cnt_d = '0;
         bit_idx_d  = '0;
      end else begin
         case (state_q)
            IDLE: ;
            CONVERT: begin
               if (conv_cnt_q == LastConv) begin
                  state_d   = SHIFT;
                  bit_idx_d = '0;
                  drr_d     = words[FrameBits-1];
                  drdy_n_d  = 1'b0;
                  shreg_d   = words << 1;
               end else begin
                  conv_cnt_d = conv_cnt_q + 1'b1;
               end
            end
            SHIFT: begin
               if (bit_idx_q == LastBit) begin
                  frame_cnt_d = frame_cnt_q + 1'b1;
                  ramp_d      = ramp_q + 1'b1;
                  alt_d       = ~alt_q;
                  conv_cnt_d  = '0;
                  state_d     = continuous ? CONVERT : IDLE;
               end else begin
                  bit_idx_d = bit_idx_q + 1'b1;
                  drr_d     = shreg_q[FrameBits-1];
                  shreg_d   = shreg_q << 1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clkx) begin
      if (rst) begin
         state_q     <= IDLE;
         conv_cnt_q  <= '0;
         bit_idx_q   <= '0;
         shreg_q     <= '0;
         drr_q       <= 1'b0;
         drdy_n_q    <= 1'b1;
         frame_cnt_q <= '0;
         ramp_q      <= '0;
         alt_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         conv_cnt_q  <= conv_cnt_d;
         bit_idx_q   <= bit_idx_d;
         shreg_q     <= shreg_d;
         drr_q       <= drr_d;
         drdy_n_q    <= drdy_n_d;
         frame_cnt_q <= frame_cnt_d;
         ramp_q      <= ramp_d;
         alt_q       <= alt_d;
      end
   end

   assign clkr      = clkx;
   assign drr       = drr_q;
   assign drdy_n    = drdy_n_q;
   assign frame_cnt = frame_cnt_q;
   assign busy      = (state_q != IDLE);
   assign fsr       = FS_ACTIVE_LOW ? drdy_n_q : ~drdy_n_q;

endmodule

// File: tb/tb_ads_tdm_adc_model.sv
// Directed bench: default 24x4 instance for framing/abort/reset, and an 8x4 instance for wrap and fsr.
module tb_ads_tdm_adc_model;

   logic clkx = 1'b0;
   always #5 clkx = ~clkx;

   // Instance 1: default parameters
   logic        d1_rst, d1_start, d1_cont;
   logic [1:0]  d1_pat;
   logic [23:0] d1_fixed;
   logic        d1_clkr, d1_drdy_n, d1_fsr, d1_drr, d1_busy;
   logic [15:0] d1_frame_cnt;

   // Instance 2: 8-bit words, 1-cycle conversion, active-high fsr
   logic        d2_rst, d2_start, d2_cont;
   logic [1:0]  d2_pat;
   logic [7:0]  d2_fixed;
   logic        d2_clkr, d2_drdy_n, d2_fsr, d2_drr, d2_busy;
   logic [15:0] d2_frame_cnt;

   ads_tdm_adc_model u_dut1 (
      .clkx        (clkx),
      .rst         (d1_rst),
      .clkr        (d1_clkr),
      .fsx         (1'b0),
      .start       (d1_start),
      .continuous  (d1_cont),
      .pattern_sel (d1_pat),
      .fixed_word  (d1_fixed),
      .drdy_n      (d1_drdy_n),
      .fsr         (d1_fsr),
      .drr         (d1_drr),
      .busy        (d1_busy),
      .frame_cnt   (d1_frame_cnt)
   );

   ads_tdm_adc_model #(
      .DATA_WIDTH    (8),
      .NUM_CH        (4),
      .CONV_CYCLES   (1),
      .FS_ACTIVE_LOW (1'b0)
   ) u_dut2 (
      .clkx        (clkx),
      .rst         (d2_rst),
      .clkr        (d2_clkr),
      .fsx         (1'b0),
      .start       (d2_start),
      .continuous  (d2_cont),
      .pattern_sel (d2_pat),
      .fixed_word  (d2_fixed),
      .drdy_n      (d2_drdy_n),
      .fsr         (d2_fsr),
      .drr         (d2_drr),
      .busy        (d2_busy),
      .frame_cnt   (d2_frame_cnt)
   );

   int checks = 0;
   int failures = 0;
   logic [23:0] cap[4];
   logic [7:0]  cap2[4];

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Steps negedges until instance 1 shows drdy_n low, within a budget.
   task automatic wait_frame(input string tag, input int budget, output int waited);
      waited = 0;
      while (d1_drdy_n !== 1'b0 && waited < budget) begin
         @(negedge clkx);
         waited++;
      end
      check_eq({tag, "_drdy_seen"}, d1_drdy_n, 1'b0);
   endtask

   // Called at the k=0 negedge; leaves the bench at the k=F-1 negedge.
   task automatic grab_frame(input string tag);
      int lows = 0;
      for (int k = 0; k < 96; k++) begin
         if (k > 0) @(negedge clkx);
         cap[k/24] = {cap[k/24][22:0], d1_drr};
         if (d1_drdy_n === 1'b0) lows++;
      end
      check_eq({tag, "_drdy_lows"}, lows, 1);
   endtask

   task automatic run_single(input string tag, input logic [1:0] pat, input logic [23:0] fw);
      int waited;
      d1_pat   = pat;
      d1_fixed = fw;
      d1_cont  = 1'b0;
      d1_start = 1'b1;
      @(negedge clkx);
      d1_start = 1'b0;
      check_eq({tag, "_busy_rise"}, d1_busy, 1'b1);
      wait_frame(tag, 40, waited);
      check_eq({tag, "_latency"}, waited + 1, 17);
      grab_frame(tag);
      @(negedge clkx);
      check_eq({tag, "_busy_fall"}, d1_busy, 1'b0);
   endtask

   initial begin
      int waited;
      int viol;
      int nframes;
      int fsr_bad;
      int fsr_high;

      d1_rst = 1'b1; d1_start = 1'b0; d1_cont = 1'b0; d1_pat = 2'd0; d1_fixed = '0;
      d2_rst = 1'b1; d2_start = 1'b0; d2_cont = 1'b0; d2_pat = 2'd0; d2_fixed = '0;
      repeat (3) @(negedge clkx);
      check_eq("rst_drdy_n", d1_drdy_n, 1'b1);
      check_eq("rst_fsr", d1_fsr, 1'b1);
      check_eq("rst_drr", d1_drr, 1'b0);
      check_eq("rst_busy", d1_busy, 1'b0);
      check_eq("rst_frame_cnt", d1_frame_cnt, 16'd0);
      check_eq("rst_clkr", d1_clkr, 1'b0);
      d1_rst = 1'b0;

      // FIXED single shot
      run_single("t1", 2'd0, 24'hCACF0C);
      for (int i = 0; i < 4; i++) check_eq($sformatf("t1_ch%0d", i), cap[i], 24'hCACF0C);
      check_eq("t1_frame_cnt", d1_frame_cnt, 16'd1);

      // CH_TAG
      run_single("t2", 2'd1, 24'hABCDE0);
      for (int i = 0; i < 4; i++)
         check_eq($sformatf("t2_ch%0d", i), cap[i], 24'hABCDE0 + 24'(i));
      check_eq("t2_frame_cnt", d1_frame_cnt, 16'd2);

      // ALT: phase 0 after two frames, then phase 1
      run_single("ta0", 2'd3, 24'h0F00F0);
      for (int i = 0; i < 4; i++) check_eq($sformatf("ta0_ch%0d", i), cap[i], 24'h0F00F0);
      run_single("ta1", 2'd3, 24'h0F00F0);
      for (int i = 0; i < 4; i++) check_eq($sformatf("ta1_ch%0d", i), cap[i], 24'hF0FF0F);
      check_eq("ta_frame_cnt", d1_frame_cnt, 16'd4);

      // RAMP continuous from a fresh ramp counter; continuous drops mid-frame 2
      d1_rst = 1'b1;
      @(negedge clkx);
      d1_rst = 1'b0;
      check_eq("t3_rst_frame_cnt", d1_frame_cnt, 16'd0);
      d1_pat = 2'd2; d1_cont = 1'b1; d1_start = 1'b1;
      @(negedge clkx);
      d1_start = 1'b0;
      for (int f = 0; f < 3; f++) begin
         wait_frame($sformatf("t3_f%0d", f), 200, waited);
         if (f > 0) check_eq($sformatf("t3_spacing%0d", f), 95 + waited, 112);
         if (f == 2) d1_cont = 1'b0;
         grab_frame($sformatf("t3_f%0d", f));
         for (int i = 0; i < 4; i++)
            check_eq($sformatf("t3_f%0d_ch%0d", f, i), cap[i], 24'(f + i));
      end
      @(negedge clkx);
      check_eq("t3_busy_fall", d1_busy, 1'b0);
      check_eq("t3_frame_cnt", d1_frame_cnt, 16'd3);

      // Abort at bit 40 of a frame
      d1_pat = 2'd1; d1_fixed = 24'h123450; d1_start = 1'b1;
      @(negedge clkx);
      d1_start = 1'b0;
      wait_frame("t5", 40, waited);
      repeat (40) @(negedge clkx);
      d1_start = 1'b1;
      @(negedge clkx);
      d1_start = 1'b0;
      check_eq("t5_frame_cnt_abort", d1_frame_cnt, 16'd3);
      viol = 0;
      for (int i = 0; i < 16; i++) begin
         if (d1_drr !== 1'b0 || d1_drdy_n !== 1'b1) viol++;
         @(negedge clkx);
      end
      check_eq("t5_convert_quiet", viol, 0);
      check_eq("t5_restart_drdy", d1_drdy_n, 1'b0);
      grab_frame("t5");
      for (int i = 0; i < 4; i++)
         check_eq($sformatf("t5_ch%0d", i), cap[i], 24'h123450 + 24'(i));
      @(negedge clkx);
      check_eq("t5_frame_cnt", d1_frame_cnt, 16'd4);

      // Reset together with start in mid-SHIFT
      d1_pat = 2'd0; d1_fixed = 24'hFFFFFF; d1_cont = 1'b1; d1_start = 1'b1;
      @(negedge clkx);
      d1_start = 1'b0;
      wait_frame("t6", 40, waited);
      repeat (10) @(negedge clkx);
      d1_rst = 1'b1; d1_start = 1'b1;
      @(negedge clkx);
      d1_rst = 1'b0; d1_start = 1'b0;
      check_eq("t6_drdy_n", d1_drdy_n, 1'b1);
      check_eq("t6_drr", d1_drr, 1'b0);
      check_eq("t6_busy", d1_busy, 1'b0);
      check_eq("t6_frame_cnt", d1_frame_cnt, 16'd0);
      repeat (3) @(negedge clkx);
      check_eq("t6_busy_later", d1_busy, 1'b0);

      // 8-bit RAMP wrap at ramp counter FE, plus active-high fsr
      d2_rst = 1'b0; d2_pat = 2'd2; d2_cont = 1'b1; d2_start = 1'b1;
      @(negedge clkx);
      d2_start = 1'b0;
      nframes = 0; fsr_bad = 0; fsr_high = 0;
      for (int c = 0; c < 9000; c++) begin
         @(negedge clkx);
         if (d2_fsr !== ~d2_drdy_n) fsr_bad++;
         if (d2_fsr === 1'b1) fsr_high++;
         if (d2_drdy_n === 1'b0) begin
            nframes++;
            if (nframes == 255) break;
         end
      end
      check_eq("t4_frames_seen", nframes, 255);
      check_eq("t4_frame_cnt", d2_frame_cnt, 16'd254);
      for (int k = 0; k < 32; k++) begin
         if (k > 0) @(negedge clkx);
         if (d2_fsr !== ~d2_drdy_n) fsr_bad++;
         cap2[k/8] = {cap2[k/8][6:0], d2_drr};
      end
      check_eq("t4_ch0", cap2[0], 8'hFE);
      check_eq("t4_ch1", cap2[1], 8'hFF);
      check_eq("t4_ch2", cap2[2], 8'h00);
      check_eq("t4_ch3", cap2[3], 8'h01);
      check_eq("t6_fsr_tracks", fsr_bad, 0);
      check_eq("t6_fsr_pulses", fsr_high, 255);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ads_tdm_adc_model.md
Name: ads_tdm_adc_model

Overview:
Parametrised successor to the single-channel ADS1672 EVM device model. It emulates a multi-channel serial ADC that returns time-division-multiplexed conversion frames to the processor serial port. It supports single-shot and continuous conversion, a configurable conversion interval and selectable data patterns, so the bench can check multi-channel framing and sustained streaming.

Parameters:
DATA_WIDTH, 24, bits per channel sample, MSB first; legal range 8..32.
NUM_CH, 4, channels per frame, serialised ch0 first; legal range 1..16.
CONV_CYCLES, 16, clkx cycles spent in CONVERT before each frame; must be ≥1.
FS_ACTIVE_LOW, 1, 1 makes fsr an active-low copy of drdy_n; 0 makes fsr active-high.

Ports:
clkx  in  1  serial transmit clock from processor; the only clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
clkr  out  1  serial receive clock to processor; combinationally equal to clkx.
fsx  in  1  frame sync from processor; ignored, present for pin compatibility.
start  in  1  one-cycle pulse that begins a conversion sequence.
continuous  in  1  1 = free-run frames; 0 = single frame then idle.
pattern_sel  in  2  0 FIXED, 1 CH_TAG, 2 RAMP, 3 ALT.
fixed_word  in  DATA_WIDTH  base pattern word.
drdy_n  out  1  data-ready, low for exactly one cycle coincident with the first frame bit.
fsr  out  1  frame sync to processor, derived from drdy_n per FS_ACTIVE_LOW.
drr  out  1  serial data to processor.
busy  out  1  high in any state other than IDLE.
frame_cnt  out  16  count of completed frames since reset; wraps at 2^16.

Behaviour:
- Reset: state IDLE, drdy_n=1, fsr inactive, drr=0, busy=0, frame_cnt=0, ramp counter=0, alt phase=0. Reset wins over start.
- The FSM states are IDLE, CONVERT, SHIFT.
- IDLE: drr=0. When start=1, go to CONVERT with the interval counter cleared, and set busy=1 on the next cycle.
- CONVERT: stays for CONV_CYCLES cycles, then enters SHIFT. On that transition:
  - latch NUM_CH sample words from the pattern generator;
  - load the bit index with 0.
- SHIFT: frame length F = NUM_CH*DATA_WIDTH cycles. In cycle k (0..F-1), drr = bit (DATA_WIDTH-1 - k mod DATA_WIDTH) of channel k/DATA_WIDTH.
  - drdy_n=0 only in cycle k=0; 1 otherwise.
  - The frame's first bit appears 1+CONV_CYCLES cycles after the start pulse cycle.
- End of frame (cycle F-1): on the next edge, increment frame_cnt and advance the ramp counter and alt phase.
  - If continuous=1 (sampled in cycle F-1), go to CONVERT.
  - Otherwise go to IDLE.
- Patterns, evaluated once per frame at latch time (mid-frame pattern changes affect the next frame only):
  - FIXED: every channel = fixed_word.
  - CH_TAG: fixed_word with its low 4 bits replaced by the channel index.
  - RAMP: ramp_counter + channel index, modulo 2^DATA_WIDTH; ramp counter +1 per frame, wrapping.
  - ALT: fixed_word when alt phase=0, ~fixed_word when 1.
- start while busy aborts the current frame:
  - on the next edge go to CONVERT with counters cleared;
  - frame_cnt is not incremented for the aborted frame;
  - drr=0 and drdy_n=1 during the restarted CONVERT.
- Deasserting continuous mid-frame lets the current frame complete; the FSM then returns to IDLE.
- Outputs drdy_n, drr and frame_cnt are registered. fsr and clkr are combinational.

Decomposition:
- Package ads_adc_pkg holds:
  - state_t enum (IDLE, CONVERT, SHIFT);
  - pattern_t enum (PAT_FIXED=0, PAT_CH_TAG=1, PAT_RAMP=2, PAT_ALT=3);
  - constant FRAME_CNT_W=16.
- Sub-module ads_pattern_gen computes the NUM_CH sample words from pattern_sel, fixed_word, ramp counter, alt phase and channel index.
- The top module holds the FSM, interval counter, shifter and frame_cnt.

Test Plan:
1. Defaults, FIXED, fixed_word=24'hCACF0C, continuous=0, pulse start -> after 16 CONVERT cycles, drdy_n low for one cycle, then 96 bits of CACF0C repeated 4×, MSB first; busy falls; frame_cnt=1.
2. CH_TAG, fixed_word=24'hABCDE0, NUM_CH=4 -> words ABCDE0, ABCDE1, ABCDE2, ABCDE3 in order, with no gap between channels.
3. RAMP, continuous=1 for 3 frames -> frame0 ch0..3 = 0,1,2,3; frame1 = 1,2,3,4; frame2 = 2,3,4,5; drdy_n pulses spaced exactly 96+16 cycles apart.
4. DATA_WIDTH=8, RAMP with ramp counter at 8'hFE -> ch0..3 = FE, FF, 00, 01 (wrap).
5. start reasserted in cycle 40 of a frame -> drr=0 and drdy_n=1 for 16 cycles; the new frame begins from ch0 MSB; frame_cnt is unchanged by the aborted frame.
6. rst asserted mid-SHIFT together with start -> next cycle drdy_n=1, drr=0, busy=0, frame_cnt=0; start is ignored. With FS_ACTIVE_LOW=0, fsr is high exactly in drdy_n-low cycles.
